// File: rtl/snn_batch_sched.sv
// Batch scheduler sharing one snn_core across NUM_SAMPLES sample RAMs.
// Define SNN_BATCH_SCHED_TIMEOUT_EN to add the WAIT watchdog and timeout_flag.
module snn_batch_sched #(
  parameter int NUM_SAMPLES = 10,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 5,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [NUM_SAMPLES-1:0] sample_mask,
  output logic                   busy,
  output logic                   batch_done,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [3:0]             core_digit,
  input  logic [ADDR_W-1:0]      core_addr,
  output logic                   core_q,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [NUM_SAMPLES-1:0] ram_q,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [3:0]             res_index,
  output logic [3:0]             res_digit,
  output logic                   res_pass,
  output logic [CNT_W-1:0]       pass_cnt,
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   timeout_flag
`else
  output logic [CNT_W-1:0]       fail_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_REPORT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_SAMPLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [NUM_SAMPLES-1:0] mask_q, mask_d;
  logic                   done_d_q;
  logic                   done_rise;
  logic [3:0]             index_q, index_d;
  logic [3:0]             digit_q, digit_d;
  logic                   pass_q, pass_d;
  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;

`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tflag_q, tflag_d;
  assign timeout_flag = tflag_q;
`endif

  assign done_rise  = core_done & ~done_d_q;
  assign ram_addr   = core_addr;
  assign core_q     = ram_q[idx_q];
  assign busy       = (state_q != S_IDLE);
  assign batch_done = (state_q == S_DONE);
  assign core_start = (state_q == S_START);
  assign res_valid  = (state_q == S_REPORT);
  assign res_index  = index_q;
  assign res_digit  = digit_q;
  assign res_pass   = pass_q;
  assign pass_cnt   = pcnt_q;
  assign fail_cnt   = fcnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    index_d = index_q;
    digit_d = digit_q;
    pass_d  = pass_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
    tflag_d = tflag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          mask_d  = sample_mask;
          pcnt_d  = '0;
          fcnt_d  = '0;
          idx_d   = '0;
          state_d = S_SCAN;
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
          tflag_d = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        if (mask_q[idx_q]) begin
          state_d = S_START;
        end else if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      S_WAIT: begin
        if (done_rise) begin
          index_d = idx_q;
          digit_d = core_digit;
          pass_d  = (core_digit == idx_q);
          state_d = S_REPORT;
          if (core_digit == idx_q) begin
            if (pcnt_q != '1) pcnt_d = pcnt_q + CNT_W'(1);
          end else begin
            if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
          end
        end
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
        // A hung core is graded as a fail with digit F.
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          index_d = idx_q;
          digit_d = 4'hF;
          pass_d  = 1'b0;
          tflag_d = 1'b1;
          state_d = S_REPORT;
          if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_REPORT: begin
        if (res_ready) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      done_d_q <= 1'b0;
      index_q  <= '0;
      digit_q  <= '0;
      pass_q   <= 1'b0;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
      wd_q     <= '0;
      tflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      done_d_q <= core_done;
      index_q  <= index_d;
      digit_q  <= digit_d;
      pass_q   <= pass_d;
      pcnt_q   <= pcnt_d;
      fcnt_q   <= fcnt_d;
`ifdef SNN_BATCH_SCHED_TIMEOUT_EN
      wd_q     <= wd_d;
      tflag_q  <= tflag_d;
`endif
    end
  end

endmodule
